// File: rtl/store_commit_scheduler_if.sv
// Data-memory write port between the store commit scheduler and the memory.
interface store_commit_scheduler_if #(
  parameter int unsigned XLEN = 32
) ();

  logic              mem_req_valid;
  logic              mem_req_ready;
  logic [XLEN-1:0]   mem_req_addr;
  logic [XLEN-1:0]   mem_req_data;
  logic [XLEN/8-1:0] mem_req_wstrb;
  logic              mem_resp_valid;

  modport master (
    output mem_req_valid, mem_req_addr, mem_req_data, mem_req_wstrb,
    input  mem_req_ready, mem_resp_valid
  );

  modport slave (
    input  mem_req_valid, mem_req_addr, mem_req_data, mem_req_wstrb,
    output mem_req_ready, mem_resp_valid
  );

endinterface

// File: rtl/store_commit_scheduler.sv
// Drains the committed store-queue head into the data-memory port, one store at a time,
// sharing the port with the load path under a starvation guard.
module store_commit_scheduler #(
  parameter int unsigned XLEN          = 32,
  parameter int unsigned ROB_TAG_WIDTH = 32,
  parameter int unsigned STQ_SIZE      = 32,
  parameter int unsigned STARVE_LIMIT  = 4
) (
  input  logic                                    clk,
  input  logic                                    reset,
  input  logic [$clog2(STQ_SIZE)-1:0]             stq_head,
  input  logic [STQ_SIZE-1:0]                     stq_valid,
  input  logic [STQ_SIZE-1:0]                     stq_committed,
  input  logic [STQ_SIZE-1:0]                     stq_address_valid,
  input  logic [STQ_SIZE-1:0]                     stq_data_valid,
  input  logic [STQ_SIZE-1:0]                     stq_executed,
  input  logic [STQ_SIZE-1:0][XLEN-1:0]           stq_address,
  input  logic [STQ_SIZE-1:0][XLEN-1:0]           stq_data,
  input  logic [STQ_SIZE-1:0][ROB_TAG_WIDTH-1:0]  stq_rob_tag,
  input  logic [STQ_SIZE-1:0][1:0]                stq_funct3,
  output logic                                    store_fired,
  output logic [$clog2(STQ_SIZE)-1:0]             store_fired_index,
  output logic                                    store_succeeded,
  output logic [ROB_TAG_WIDTH-1:0]                store_succeeded_rob_tag,
  input  logic                                    load_req,
  output logic                                    load_grant,
  store_commit_scheduler_if.master                mem
);

  localparam int unsigned IdxW  = $clog2(STQ_SIZE);
  localparam int unsigned CntW  = $clog2(STARVE_LIMIT + 1);
  localparam int unsigned StrbW = XLEN / 8;

  typedef enum logic [1:0] {StIdle, StReq, StWaitAck} state_e;

  state_e                   state_q, state_d;
  logic [CntW-1:0]          starve_q, starve_d;
  logic [IdxW-1:0]          idx_q, idx_d;
  logic [ROB_TAG_WIDTH-1:0] tag_q, tag_d;
  logic [XLEN-1:0]          addr_q, addr_d;
  logic [XLEN-1:0]          data_q, data_d;
  logic [1:0]               f3_q, f3_d;
  logic                     fired_q, fired_d;
  logic                     succ_q, succ_d;
  logic [ROB_TAG_WIDTH-1:0] succ_tag_q, succ_tag_d;

  logic head_eligible;
  logic starve_full;
  logic store_grant;

  assign head_eligible = stq_valid[stq_head] & stq_committed[stq_head] &
                         stq_address_valid[stq_head] & stq_data_valid[stq_head] &
                         ~stq_executed[stq_head];
  assign starve_full   = (starve_q == CntW'(STARVE_LIMIT));
  assign store_grant   = (state_q == StIdle) && head_eligible && (!load_req || starve_full);

  assign store_fired             = fired_q;
  assign store_fired_index       = idx_q;
  assign store_succeeded         = succ_q;
  assign store_succeeded_rob_tag = succ_tag_q;

  // Next-state, transaction latch, starvation counter and load arbitration.
  always_comb begin
    state_d    = state_q;
    starve_d   = starve_q;
    idx_d      = idx_q;
    tag_d      = tag_q;
    addr_d     = addr_q;
    data_d     = data_q;
    f3_d       = f3_q;
    fired_d    = 1'b0;
    succ_d     = 1'b0;
    succ_tag_d = succ_tag_q;
    load_grant = 1'b0;

    unique case (state_q)
      StIdle: begin
        load_grant = load_req && !store_grant;
        if (store_grant) begin
          idx_d   = stq_head;
          tag_d   = stq_rob_tag[stq_head];
          addr_d  = stq_address[stq_head];
          data_d  = stq_data[stq_head];
          f3_d    = stq_funct3[stq_head];
          fired_d = 1'b1;
          state_d = StReq;
        end
      end
      StReq: begin
        if (mem.mem_req_ready) state_d = StWaitAck;
      end
      StWaitAck: begin
        if (mem.mem_resp_valid) begin
          state_d    = StIdle;
          succ_d     = 1'b1;
          succ_tag_d = tag_q;
        end
      end
      default: state_d = StIdle;
    endcase

    // A blocked eligible head counts up until it may override the load path.
    if (!head_eligible || store_grant) begin
      starve_d = '0;
    end else if ((state_q == StIdle) && load_req && !starve_full) begin
      starve_d = starve_q + CntW'(1);
    end
  end

  // Memory request lanes; everything is zero outside the request phase.
  always_comb begin
    mem.mem_req_valid = 1'b0;
    mem.mem_req_addr  = '0;
    mem.mem_req_data  = '0;
    mem.mem_req_wstrb = '0;
    if (state_q == StReq) begin
      mem.mem_req_valid = 1'b1;
      mem.mem_req_addr  = {addr_q[XLEN-1:2], 2'b00};
      unique case (f3_q)
        2'b00: begin
          mem.mem_req_wstrb = StrbW'(4'b0001) << addr_q[1:0];
          mem.mem_req_data  = {StrbW{data_q[7:0]}};
        end
        2'b01: begin
          // a[0] is ignored: the AGU never issues a misaligned halfword.
          mem.mem_req_wstrb = StrbW'(4'b0011) << {addr_q[1], 1'b0};
          mem.mem_req_data  = {(XLEN/16){data_q[15:0]}};
        end
        default: begin
          mem.mem_req_wstrb = {StrbW{1'b1}};
          mem.mem_req_data  = data_q;
        end
      endcase
    end
  end

  // State register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= StIdle;
      starve_q   <= '0;
      idx_q      <= '0;
      tag_q      <= '0;
      addr_q     <= '0;
      data_q     <= '0;
      f3_q       <= '0;
      fired_q    <= 1'b0;
      succ_q     <= 1'b0;
      succ_tag_q <= '0;
    end else begin
      state_q    <= state_d;
      starve_q   <= starve_d;
      idx_q      <= idx_d;
      tag_q      <= tag_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      f3_q       <= f3_d;
      fired_q    <= fired_d;
      succ_q     <= succ_d;
      succ_tag_q <= succ_tag_d;
    end
  end

endmodule

// File: tb/tb_store_commit_scheduler.sv
// Directed bench for store_commit_scheduler: sizes, back-pressure, starvation, reset.
module tb_store_commit_scheduler;

  logic              clk = 1'b0;
  logic              reset;
  logic [4:0]        stq_head;
  logic [31:0]       stq_valid, stq_committed, stq_address_valid, stq_data_valid, stq_executed;
  logic [31:0][31:0] stq_address, stq_data, stq_rob_tag;
  logic [31:0][1:0]  stq_funct3;
  logic              store_fired;
  logic [4:0]        store_fired_index;
  logic              store_succeeded;
  logic [31:0]       store_succeeded_rob_tag;
  logic              load_req, load_grant;

  int checks = 0;
  int errors = 0;
  int nfired;

  store_commit_scheduler_if #(.XLEN(32)) mem_if ();

  store_commit_scheduler #(
    .XLEN(32), .ROB_TAG_WIDTH(32), .STQ_SIZE(32), .STARVE_LIMIT(4)
  ) dut (
    .clk                     (clk),
    .reset                   (reset),
    .stq_head                (stq_head),
    .stq_valid               (stq_valid),
    .stq_committed           (stq_committed),
    .stq_address_valid       (stq_address_valid),
    .stq_data_valid          (stq_data_valid),
    .stq_executed            (stq_executed),
    .stq_address             (stq_address),
    .stq_data                (stq_data),
    .stq_rob_tag             (stq_rob_tag),
    .stq_funct3              (stq_funct3),
    .store_fired             (store_fired),
    .store_fired_index       (store_fired_index),
    .store_succeeded         (store_succeeded),
    .store_succeeded_rob_tag (store_succeeded_rob_tag),
    .load_req                (load_req),
    .load_grant              (load_grant),
    .mem                     (mem_if)
  );

  always #5 clk = ~clk;

  // Advance to just after the next rising edge; inputs are driven here.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load_head(input int idx, input logic [31:0] a, input logic [31:0] d,
                           input logic [31:0] tag, input logic [1:0] f3, input logic dv);
    stq_head               = idx[4:0];
    stq_valid[idx]         = 1'b1;
    stq_committed[idx]     = 1'b1;
    stq_address_valid[idx] = 1'b1;
    stq_data_valid[idx]    = dv;
    stq_executed[idx]      = 1'b0;
    stq_address[idx]       = a;
    stq_data[idx]          = d;
    stq_rob_tag[idx]       = tag;
    stq_funct3[idx]        = f3;
  endtask

  task automatic retire(input int idx);
    stq_valid[idx]         = 1'b0;
    stq_committed[idx]     = 1'b0;
    stq_address_valid[idx] = 1'b0;
    stq_data_valid[idx]    = 1'b0;
    stq_executed[idx]      = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    stq_head = '0; stq_valid = '0; stq_committed = '0; stq_address_valid = '0;
    stq_data_valid = '0; stq_executed = '0; stq_address = '0; stq_data = '0;
    stq_rob_tag = '0; stq_funct3 = '0; load_req = 1'b0;
    mem_if.mem_req_ready = 1'b0; mem_if.mem_resp_valid = 1'b0;
    step(); step(); #1;
    checks++; if (store_fired !== 1'b0) begin errors++; $display("FAIL rst_fired got %0h want 0", store_fired); end
    checks++; if (store_fired_index !== 5'd0) begin errors++; $display("FAIL rst_idx got %0h want 0", store_fired_index); end
    checks++; if (store_succeeded !== 1'b0) begin errors++; $display("FAIL rst_succ got %0h want 0", store_succeeded); end
    checks++; if (store_succeeded_rob_tag !== 32'd0) begin errors++; $display("FAIL rst_tag got %0h want 0", store_succeeded_rob_tag); end
    checks++; if (load_grant !== 1'b0) begin errors++; $display("FAIL rst_lg got %0h want 0", load_grant); end
    checks++; if (mem_if.mem_req_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got %0h want 0", mem_if.mem_req_valid); end
    checks++; if (mem_if.mem_req_addr !== 32'd0) begin errors++; $display("FAIL rst_addr got %0h want 0", mem_if.mem_req_addr); end
    checks++; if (mem_if.mem_req_data !== 32'd0) begin errors++; $display("FAIL rst_data got %0h want 0", mem_if.mem_req_data); end
    checks++; if (mem_if.mem_req_wstrb !== 4'd0) begin errors++; $display("FAIL rst_wstrb got %0h want 0", mem_if.mem_req_wstrb); end
    reset = 1'b1;
    step();
  endtask

  task automatic test_sw();
    load_head(0, 32'h104, 32'hDEADBEEF, 32'h55, 2'b10, 1'b1);
    mem_if.mem_req_ready = 1'b1;
    #1;
    checks++; if (store_fired !== 1'b0) begin errors++; $display("FAIL sw_fire_early got %0h want 0", store_fired); end
    checks++; if (load_grant !== 1'b0) begin errors++; $display("FAIL sw_lg got %0h want 0", load_grant); end
    step(); #1;
    checks++; if (store_fired !== 1'b1) begin errors++; $display("FAIL sw_fired got %0h want 1", store_fired); end
    checks++; if (store_fired_index !== 5'd0) begin errors++; $display("FAIL sw_idx got %0h want 0", store_fired_index); end
    checks++; if (mem_if.mem_req_valid !== 1'b1) begin errors++; $display("FAIL sw_valid got %0h want 1", mem_if.mem_req_valid); end
    checks++; if (mem_if.mem_req_addr !== 32'h104) begin errors++; $display("FAIL sw_addr got %0h want 104", mem_if.mem_req_addr); end
    checks++; if (mem_if.mem_req_wstrb !== 4'b1111) begin errors++; $display("FAIL sw_wstrb got %0h want f", mem_if.mem_req_wstrb); end
    checks++; if (mem_if.mem_req_data !== 32'hDEADBEEF) begin errors++; $display("FAIL sw_data got %0h want deadbeef", mem_if.mem_req_data); end
    step(); stq_executed[0] = 1'b1; #1;
    checks++; if (mem_if.mem_req_valid !== 1'b0) begin errors++; $display("FAIL sw_valid_wait got %0h want 0", mem_if.mem_req_valid); end
    checks++; if (store_fired !== 1'b0) begin errors++; $display("FAIL sw_fire_once got %0h want 0", store_fired); end
    step(); mem_if.mem_resp_valid = 1'b1; #1;
    checks++; if (store_succeeded !== 1'b0) begin errors++; $display("FAIL sw_succ_early got %0h want 0", store_succeeded); end
    step(); mem_if.mem_resp_valid = 1'b0; #1;
    checks++; if (store_succeeded !== 1'b1) begin errors++; $display("FAIL sw_succ got %0h want 1", store_succeeded); end
    checks++; if (store_succeeded_rob_tag !== 32'h55) begin errors++; $display("FAIL sw_tag got %0h want 55", store_succeeded_rob_tag); end
    retire(0);
    step(); #1;
    checks++; if (store_succeeded !== 1'b0) begin errors++; $display("FAIL sw_succ_pulse got %0h want 0", store_succeeded); end
  endtask

  task automatic test_sb_sh();
    load_head(1, 32'h203, 32'h000000A5, 32'h7, 2'b00, 1'b1);
    step(); #1;
    checks++; if (store_fired_index !== 5'd1) begin errors++; $display("FAIL sb_idx got %0h want 1", store_fired_index); end
    checks++; if (mem_if.mem_req_addr !== 32'h200) begin errors++; $display("FAIL sb_addr got %0h want 200", mem_if.mem_req_addr); end
    checks++; if (mem_if.mem_req_wstrb !== 4'b1000) begin errors++; $display("FAIL sb_wstrb got %0h want 8", mem_if.mem_req_wstrb); end
    checks++; if (mem_if.mem_req_data !== 32'hA5A5A5A5) begin errors++; $display("FAIL sb_data got %0h want a5a5a5a5", mem_if.mem_req_data); end
    step(); stq_executed[1] = 1'b1; mem_if.mem_resp_valid = 1'b1;
    step(); mem_if.mem_resp_valid = 1'b0; #1;
    checks++; if (store_succeeded_rob_tag !== 32'h7) begin errors++; $display("FAIL sb_tag got %0h want 7", store_succeeded_rob_tag); end
    retire(1);
    load_head(2, 32'h202, 32'h00001234, 32'h8, 2'b01, 1'b1);
    step(); #1;
    checks++; if (store_fired_index !== 5'd2) begin errors++; $display("FAIL sh_idx got %0h want 2", store_fired_index); end
    checks++; if (mem_if.mem_req_addr !== 32'h200) begin errors++; $display("FAIL sh_addr got %0h want 200", mem_if.mem_req_addr); end
    checks++; if (mem_if.mem_req_wstrb !== 4'b1100) begin errors++; $display("FAIL sh_wstrb got %0h want c", mem_if.mem_req_wstrb); end
    checks++; if (mem_if.mem_req_data !== 32'h12341234) begin errors++; $display("FAIL sh_data got %0h want 12341234", mem_if.mem_req_data); end
    step(); stq_executed[2] = 1'b1; mem_if.mem_resp_valid = 1'b1;
    step(); mem_if.mem_resp_valid = 1'b0; #1;
    checks++; if (store_succeeded_rob_tag !== 32'h8) begin errors++; $display("FAIL sh_tag got %0h want 8", store_succeeded_rob_tag); end
    retire(2);
    step();
  endtask

  task automatic test_backpressure();
    mem_if.mem_req_ready = 1'b0;
    load_req = 1'b0;
    load_head(3, 32'h300, 32'h11223344, 32'h9, 2'b10, 1'b1);
    step();
    load_req = 1'b1;
    nfired = 0;
    for (int i = 0; i < 5; i++) begin
      #1;
      checks++; if (mem_if.mem_req_valid !== 1'b1) begin errors++; $display("FAIL bp_valid[%0d] got %0h want 1", i, mem_if.mem_req_valid); end
      checks++; if (mem_if.mem_req_addr !== 32'h300) begin errors++; $display("FAIL bp_addr[%0d] got %0h want 300", i, mem_if.mem_req_addr); end
      checks++; if (mem_if.mem_req_data !== 32'h11223344) begin errors++; $display("FAIL bp_data[%0d] got %0h want 11223344", i, mem_if.mem_req_data); end
      checks++; if (mem_if.mem_req_wstrb !== 4'b1111) begin errors++; $display("FAIL bp_wstrb[%0d] got %0h want f", i, mem_if.mem_req_wstrb); end
      checks++; if (load_grant !== 1'b0) begin errors++; $display("FAIL bp_lg[%0d] got %0h want 0", i, load_grant); end
      if (store_fired === 1'b1) nfired++;
      step();
      if (i == 0) stq_executed[3] = 1'b1;
    end
    mem_if.mem_req_ready = 1'b1; #1;
    checks++; if (mem_if.mem_req_valid !== 1'b1) begin errors++; $display("FAIL bp_valid_hold got %0h want 1", mem_if.mem_req_valid); end
    checks++; if (nfired !== 1) begin errors++; $display("FAIL bp_fire_count got %0d want 1", nfired); end
    step(); #1;
    checks++; if (mem_if.mem_req_valid !== 1'b0) begin errors++; $display("FAIL bp_valid_done got %0h want 0", mem_if.mem_req_valid); end
    checks++; if (load_grant !== 1'b0) begin errors++; $display("FAIL bp_lg_wait got %0h want 0", load_grant); end
    mem_if.mem_resp_valid = 1'b1;
    step(); mem_if.mem_resp_valid = 1'b0; #1;
    checks++; if (store_succeeded !== 1'b1) begin errors++; $display("FAIL bp_succ got %0h want 1", store_succeeded); end
    checks++; if (store_succeeded_rob_tag !== 32'h9) begin errors++; $display("FAIL bp_tag got %0h want 9", store_succeeded_rob_tag); end
    load_req = 1'b0;
    retire(3);
    step();
  endtask

  task automatic test_starvation();
    load_head(4, 32'h400, 32'hCAFEF00D, 32'h44, 2'b10, 1'b1);
    load_req = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++; if (load_grant !== 1'b1) begin errors++; $display("FAIL st_lg[%0d] got %0h want 1", i, load_grant); end
      step();
    end
    #1;
    checks++; if (load_grant !== 1'b0) begin errors++; $display("FAIL st_lg_override got %0h want 0", load_grant); end
    checks++; if (store_fired !== 1'b0) begin errors++; $display("FAIL st_fire_early got %0h want 0", store_fired); end
    step(); #1;
    checks++; if (store_fired !== 1'b1) begin errors++; $display("FAIL st_fired got %0h want 1", store_fired); end
    checks++; if (store_fired_index !== 5'd4) begin errors++; $display("FAIL st_idx got %0h want 4", store_fired_index); end
    checks++; if (load_grant !== 1'b0) begin errors++; $display("FAIL st_lg_req got %0h want 0", load_grant); end
    step(); stq_executed[4] = 1'b1; mem_if.mem_resp_valid = 1'b1;
    step(); mem_if.mem_resp_valid = 1'b0; #1;
    checks++; if (store_succeeded_rob_tag !== 32'h44) begin errors++; $display("FAIL st_tag got %0h want 44", store_succeeded_rob_tag); end
    load_req = 1'b0;
    retire(4);
    step();
  endtask

  task automatic test_data_wait();
    load_head(5, 32'h500, 32'h55AA55AA, 32'h5, 2'b10, 1'b0);
    load_req = 1'b0; #1;
    checks++; if (load_grant !== 1'b0) begin errors++; $display("FAIL dw_lg0 got %0h want 0", load_grant); end
    step(); #1;
    checks++; if (store_fired !== 1'b0) begin errors++; $display("FAIL dw_nofire0 got %0h want 0", store_fired); end
    checks++; if (mem_if.mem_req_valid !== 1'b0) begin errors++; $display("FAIL dw_valid got %0h want 0", mem_if.mem_req_valid); end
    load_req = 1'b1; #1;
    checks++; if (load_grant !== 1'b1) begin errors++; $display("FAIL dw_lg1 got %0h want 1", load_grant); end
    step(); #1;
    checks++; if (store_fired !== 1'b0) begin errors++; $display("FAIL dw_nofire1 got %0h want 0", store_fired); end
    load_req = 1'b0; stq_data_valid[5] = 1'b1; #1;
    checks++; if (load_grant !== 1'b0) begin errors++; $display("FAIL dw_lg2 got %0h want 0", load_grant); end
    step(); #1;
    checks++; if (store_fired !== 1'b1) begin errors++; $display("FAIL dw_fired got %0h want 1", store_fired); end
    checks++; if (store_fired_index !== 5'd5) begin errors++; $display("FAIL dw_idx got %0h want 5", store_fired_index); end
    step(); stq_executed[5] = 1'b1; mem_if.mem_resp_valid = 1'b1;
    step(); mem_if.mem_resp_valid = 1'b0; #1;
    checks++; if (store_succeeded_rob_tag !== 32'h5) begin errors++; $display("FAIL dw_tag got %0h want 5", store_succeeded_rob_tag); end
    retire(5);
    step();
  endtask

  task automatic test_reset_mid();
    load_head(6, 32'h600, 32'h0BADF00D, 32'h66, 2'b10, 1'b1);
    step(); #1;
    checks++; if (store_fired !== 1'b1) begin errors++; $display("FAIL rm_fired got %0h want 1", store_fired); end
    step(); stq_executed[6] = 1'b1;
    reset = 1'b0;
    step(); #1;
    checks++; if (mem_if.mem_req_valid !== 1'b0) begin errors++; $display("FAIL rm_valid got %0h want 0", mem_if.mem_req_valid); end
    checks++; if (store_fired_index !== 5'd0) begin errors++; $display("FAIL rm_idx got %0h want 0", store_fired_index); end
    checks++; if (store_succeeded_rob_tag !== 32'd0) begin errors++; $display("FAIL rm_tag0 got %0h want 0", store_succeeded_rob_tag); end
    checks++; if (load_grant !== 1'b0) begin errors++; $display("FAIL rm_lg got %0h want 0", load_grant); end
    reset = 1'b1;
    mem_if.mem_resp_valid = 1'b1;
    step(); mem_if.mem_resp_valid = 1'b0; #1;
    checks++; if (store_succeeded !== 1'b0) begin errors++; $display("FAIL rm_late_ack got %0h want 0", store_succeeded); end
    checks++; if (store_fired !== 1'b0) begin errors++; $display("FAIL rm_nofire0 got %0h want 0", store_fired); end
    step(); #1;
    checks++; if (store_fired !== 1'b0) begin errors++; $display("FAIL rm_nofire1 got %0h want 0", store_fired); end
    stq_executed[6] = 1'b0;
    step(); #1;
    checks++; if (store_fired !== 1'b1) begin errors++; $display("FAIL rm_refire got %0h want 1", store_fired); end
    checks++; if (store_fired_index !== 5'd6) begin errors++; $display("FAIL rm_refire_idx got %0h want 6", store_fired_index); end
    step(); stq_executed[6] = 1'b1; mem_if.mem_resp_valid = 1'b1;
    step(); mem_if.mem_resp_valid = 1'b0; #1;
    checks++; if (store_succeeded !== 1'b1) begin errors++; $display("FAIL rm_succ got %0h want 1", store_succeeded); end
    checks++; if (store_succeeded_rob_tag !== 32'h66) begin errors++; $display("FAIL rm_tag got %0h want 66", store_succeeded_rob_tag); end
    retire(6);
    step();
  endtask

  initial begin
    test_reset();
    test_sw();
    test_sb_sh();
    test_backpressure();
    test_starvation();
    test_data_wait();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/store_commit_scheduler.md
# store_commit_scheduler

Drains committed stores from the store queue into the single data-memory port, in program order, one at a time. The block watches the head entry of the store queue and fires the store once it is committed with address and data present. It runs the memory request/acknowledge handshake, then reports success back to the queue so the entry retires. It also arbitrates the shared memory port against the load path, with a starvation guard so committed stores always drain.

## Interface
- XLEN, 32, data/address width; strobe logic is defined for 32 only
- ROB_TAG_WIDTH, 32, ROB tag width
- STQ_SIZE, 32, store queue depth (power of two)
- STARVE_LIMIT, 4, consecutive blocked cycles before a store overrides a load

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-low
- stq_head  in  $clog2(STQ_SIZE)  store queue head pointer
- stq_valid, stq_committed, stq_address_valid, stq_data_valid, stq_executed  in  STQ_SIZE each  per-entry status
- stq_address, stq_data  in  STQ_SIZE×XLEN  per-entry address/data
- stq_rob_tag  in  STQ_SIZE×ROB_TAG_WIDTH  per-entry tag
- stq_funct3  in  STQ_SIZE×2  store size: 00 sb, 01 sh, 10 sw
- store_fired  out  1  one-cycle pulse, entry issued
- store_fired_index  out  $clog2(STQ_SIZE)  index of fired entry
- store_succeeded  out  1  one-cycle pulse, memory acknowledged
- store_succeeded_rob_tag  out  ROB_TAG_WIDTH  tag of completed store
- load_req  in  1  load path requests the port this cycle
- load_grant  out  1  load path owns the port this cycle
- mem_req_valid  out  1  write request valid
- mem_req_ready  in  1  memory accepts request
- mem_req_addr  out  XLEN  word-aligned address
- mem_req_data  out  XLEN  lane-replicated data
- mem_req_wstrb  out  XLEN/8  byte strobes
- mem_resp_valid  in  1  write acknowledge

## Operation
- The head entry is eligible when valid, committed, address_valid and data_valid are all set and executed is clear. Only the head entry is ever considered.
- FSM states: IDLE, REQ, WAIT_ACK.
- IDLE:
  - The store is granted when the head is eligible and either load_req=0 or starve_cnt==STARVE_LIMIT.
  - On grant, the block latches index, tag, address, data and funct3, and moves to REQ.
  - load_grant = load_req && !store granted.
- REQ:
  - mem_req_valid=1, with addr/data/wstrb held stable until the cycle where mem_req_ready=1; then the FSM moves to WAIT_ACK.
  - load_grant=0.
- WAIT_ACK:
  - load_grant=0.
  - On mem_resp_valid the FSM returns to IDLE and store_succeeded pulses, with the latched tag.
- starve_cnt:
  - Increments (saturating at STARVE_LIMIT) in IDLE when the head is eligible and load_req=1 and the store is not granted.
  - Clears on store grant and whenever the head is not eligible.
- Address and lane formatting:
  - mem_req_addr = address with bits [1:0] zeroed.
  - sb: wstrb = 4'b0001 << a[1:0]; data = byte replicated ×4.
  - sh: wstrb = 4'b0011 << {a[1],1'b0}; data = half replicated ×2.
  - sw: wstrb = 4'b1111; data unchanged.
  - Misalignment is rejected by the AGU; a[0] is ignored for sh.
  - funct3=11 is treated as sw.
- There is one outstanding store at most. Committed stores are never flushed, so the block has no flush input.

## Timing
- Reset values:
  - State IDLE, starve_cnt 0.
  - All outputs 0: store_fired, store_fired_index, store_succeeded, store_succeeded_rob_tag, load_grant, mem_req_valid, mem_req_addr, mem_req_data, mem_req_wstrb.
- store_fired and store_fired_index are registered. The pulse occurs in the first REQ cycle; the queue sets executed at the following edge.
- mem_req_valid first rises in the cycle after grant. With ready already high, REQ lasts exactly one cycle.
- mem_resp_valid is only sampled in WAIT_ACK; an acknowledge in the REQ handshake cycle is ignored.
- store_succeeded is a registered pulse in the cycle after the acknowledge is sampled, when the FSM is back in IDLE.
- The head entry then shows executed=1 until the queue retires it, so it is never reselected. The earliest next fire is 2 cycles after store_succeeded.
- Reset asserted mid-transaction forces IDLE at the next edge with all outputs 0; a late mem_resp_valid after that is ignored.
- load_grant is combinational from load_req and state/eligibility, and is valid in the same cycle.

## Test plan
- Head idx 0 committed sw, addr 0x104, data 0xDEADBEEF, ready=1, ack 2 cycles later -> store_fired idx 0 one cycle after eligibility; mem addr 0x104, wstrb 1111; store_succeeded with the correct tag exactly one cycle after ack.
- sb addr 0x203 data 0x000000A5 -> addr 0x200, wstrb 1000, data 0xA5A5A5A5. sh addr 0x202 data 0x1234 -> wstrb 1100, data 0x12341234.
- mem_req_ready low for 5 cycles -> mem_req_valid, addr, data and wstrb stay constant for all 5 cycles; single store_fired pulse; load_grant=0 throughout.
- load_req held high with an eligible head, STARVE_LIMIT=4 -> load_grant=1 for 4 cycles, then the store is granted on the 5th cycle with load_grant=0.
- Head committed but data_valid=0 -> no fire; load_grant follows load_req. Data arrives -> fire next cycle.
- Reset during WAIT_ACK, then ack arrives -> outputs 0, no store_succeeded pulse; the head is refired only once it is eligible again.
